// File: rtl/buffer_write_ctrl.sv
// buffer_write_ctrl: streams mesh-group beats into BufferPool port A; zero-fill mode compiled under BUFWR_ZERO_FILL_EN
module buffer_write_ctrl #(
    parameter int X_MAC    = 4,
    parameter int X_MESH   = 16,
    parameter int ADDR_LEN = 9,
    parameter int DATA_LEN = 32,
    localparam int BUFFER_NUM = X_MAC * X_MESH,
    localparam int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
    localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
`ifdef BUFWR_ZERO_FILL_EN
    input  logic                      zero_fill,
`endif
    input  logic [ADDR_LEN-1:0]       base_addr,
    input  logic [ADDR_LEN-1:0]       num_rows,
    input  logic [X_MAC*DATA_LEN-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [DATAWIDTH-1:0]      dina,
    output logic [ADDRWIDTH-1:0]      addra,
    output logic [BUFFER_NUM-1:0]     wea,
    output logic                      busy,
    output logic                      done
);
    localparam int MW = (X_MESH > 1) ? $clog2(X_MESH) : 1;
    localparam int GW = X_MAC * DATA_LEN;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state_q, state_d;
    logic [MW-1:0] m_q, m_d;
    logic [ADDR_LEN-1:0] a_q, a_d, r_q, r_d, nr_q, nr_d;
    logic [DATAWIDTH-1:0] dina_q, dina_d;
    logic [ADDRWIDTH-1:0] addra_q, addra_d;
    logic [BUFFER_NUM-1:0] wea_q, wea_d;
    logic [ADDR_LEN:0] r_inc;
    logic last_row;
`ifdef BUFWR_ZERO_FILL_EN
    logic zf_q, zf_d;
    assign s_ready = (state_q == WRITE) && !zf_q;
`else
    assign s_ready = state_q == WRITE;
`endif
    assign r_inc    = {1'b0, r_q} + 1'b1;
    assign last_row = r_inc == {1'b0, nr_q};
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign dina     = dina_q;
    assign addra    = addra_q;
    assign wea      = wea_q;
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        r_d     = r_q;
        nr_d    = nr_q;
        dina_d  = dina_q;
        addra_d = addra_q;
        wea_d   = '0;
`ifdef BUFWR_ZERO_FILL_EN
        zf_d    = zf_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                nr_d    = num_rows;
                a_d     = base_addr;
                m_d     = '0;
                r_d     = '0;
`ifdef BUFWR_ZERO_FILL_EN
                zf_d    = zero_fill;
`endif
                state_d = (num_rows == '0) ? DONE : WRITE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else begin
`ifdef BUFWR_ZERO_FILL_EN
            if (zf_q) begin
                dina_d  = '0;
                addra_d = {BUFFER_NUM{a_q}};
                wea_d   = '1;
                a_d     = a_q + 1'b1;
                r_d     = r_q + 1'b1;
                state_d = last_row ? DONE : WRITE;
            end else
`endif
            if (s_valid) begin
                dina_d[m_q*GW +: GW]   = s_data;
                addra_d                = {BUFFER_NUM{a_q}};
                wea_d[m_q*X_MAC +: X_MAC] = '1;
                // a full row of mesh groups advances the bank address
                if (m_q == MW'(X_MESH - 1)) begin
                    m_d     = '0;
                    a_d     = a_q + 1'b1;
                    r_d     = r_q + 1'b1;
                    state_d = last_row ? DONE : WRITE;
                end else begin
                    m_d = m_q + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            r_q     <= '0;
            nr_q    <= '0;
            dina_q  <= '0;
            addra_q <= '0;
            wea_q   <= '0;
`ifdef BUFWR_ZERO_FILL_EN
            zf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            r_q     <= r_d;
            nr_q    <= nr_d;
            dina_q  <= dina_d;
            addra_q <= addra_d;
            wea_q   <= wea_d;
`ifdef BUFWR_ZERO_FILL_EN
            zf_q    <= zf_d;
`endif
        end
    end
endmodule

// File: tb/tb_buffer_write_ctrl.sv
// tb_buffer_write_ctrl: vector table, directed sequences and random jobs against a beat-count reference model
module tb_buffer_write_ctrl;
    localparam int XM = 4, XG = 16, AL = 9, DL = 32, BN = XM * XG, GW = XM * DL;
    logic clk = 0, rst_n = 0, start = 0, s_valid = 0;
    logic [AL-1:0] base_addr = 0, num_rows = 0;
    logic [GW-1:0] s_data = 0;
`ifdef BUFWR_ZERO_FILL_EN
    logic zero_fill = 0;
`endif
    logic [BN*DL-1:0] dina;
    logic [BN*AL-1:0] addra;
    logic [BN-1:0] wea;
    logic s_ready, busy, done;
    int errs = 0, checks = 0;

    buffer_write_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BUFWR_ZERO_FILL_EN
        .zero_fill(zero_fill),
`endif
        .base_addr(base_addr), .num_rows(num_rows), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .dina(dina), .addra(addra),
        .wea(wea), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit rst_n, start, valid;
        logic [AL-1:0] base, rows;
        logic [127:0] data;
        bit busy, done, ready;
        logic [63:0] wea;
        logic [AL-1:0] addr;
    } vec_t;
    vec_t vt[12];

    // Reference model: a job is a count of accepted beats k; beat k lands in
    // group k%XG at row base+k/XG, and the job ends after rows*XG beats.
    bit m_act, m_done, m_zf;
    int m_k, m_base, m_rows, e_addr;
    logic [BN*DL-1:0] e_dina;
    logic [63:0] e_wea;

    task automatic cycle();
        int g, bad;
        e_wea = 0;
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_zf = 0; e_dina = 0; e_addr = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_act) begin
            if (start) begin
                m_base = base_addr; m_rows = num_rows; m_k = 0;
`ifdef BUFWR_ZERO_FILL_EN
                m_zf = zero_fill;
`endif
                if (num_rows == 0) m_done = 1; else m_act = 1;
            end
        end else if (m_zf) begin
            e_wea = '1; e_dina = 0; e_addr = (m_base + m_k) % 512; m_k++;
            if (m_k == m_rows) begin m_act = 0; m_done = 1; end
        end else if (s_valid) begin
            g = m_k % XG;
            e_addr = (m_base + m_k / XG) % 512;
            e_wea = 64'hF << (4 * g);
            e_dina[g*GW +: GW] = s_data;
            m_k++;
            if (m_k == m_rows * XG) begin m_act = 0; m_done = 1; end
        end
        @(posedge clk);
        @(negedge clk);
        chk("wea", wea, e_wea);
        chk("busy", busy, m_act | m_done);
        chk("done", done, m_done);
        chk("s_ready", s_ready, m_act & !m_zf);
        bad = 0;
        for (int i = 0; i < BN; i++) if (addra[i*AL +: AL] !== AL'(e_addr)) begin bad = i; break; end
        chk($sformatf("addra[%0d]", bad), addra[bad*AL +: AL], e_addr);
        bad = 0;
        for (int i = 0; i < XG; i++) if (dina[i*GW +: GW] !== e_dina[i*GW +: GW]) begin bad = i; break; end
        chk($sformatf("dina_g%0d", bad), dina[bad*GW +: GW], e_dina[bad*GW +: GW]);
    endtask

    task automatic run_job(input int base, input int rows, input int vmod);
        int budget;
        start = 1; base_addr = AL'(base); num_rows = AL'(rows);
        cycle();
        start = 0;
        budget = 0;
        while ((m_act || m_done) && budget < 2000) begin
            s_valid = ($urandom % vmod) != 0;
            s_data = {$urandom, $urandom, $urandom, $urandom};
            start = ($urandom % 8) == 0;
            num_rows = AL'($urandom % 4);
            cycle();
            budget++;
        end
        start = 0; s_valid = 0;
        if (budget >= 2000) begin
            checks++; errs++;
            $display("FAIL job_timeout: got busy after %0d cycles expected done", budget);
        end
    endtask

    initial begin
        vt[0]  = '{0, 0, 0, 0, 0, 128'h0, 0, 0, 0, 64'h0,  0};
        vt[1]  = '{1, 0, 1, 0, 0, 128'h5, 0, 0, 0, 64'h0,  0};
        vt[2]  = '{1, 1, 0, 5, 0, 128'h0, 1, 1, 0, 64'h0,  0};
        vt[3]  = '{1, 1, 0, 2, 3, 128'h0, 0, 0, 0, 64'h0,  0};
        vt[4]  = '{1, 0, 1, 0, 0, 128'h1, 0, 0, 0, 64'h0,  0};
        vt[5]  = '{1, 1, 0, 7, 1, 128'h0, 1, 0, 1, 64'h0,  0};
        vt[6]  = '{1, 1, 1, 0, 0, 128'hA, 1, 0, 1, 64'hF,  7};
        vt[7]  = '{1, 0, 0, 0, 0, 128'h0, 1, 0, 1, 64'h0,  7};
        vt[8]  = '{1, 0, 0, 0, 0, 128'h0, 1, 0, 1, 64'h0,  7};
        vt[9]  = '{1, 0, 1, 0, 0, 128'hB, 1, 0, 1, 64'hF0, 7};
        vt[10] = '{0, 0, 1, 0, 0, 128'hC, 0, 0, 0, 64'h0,  0};
        vt[11] = '{1, 0, 1, 0, 0, 128'hD, 0, 0, 0, 64'h0,  0};
        for (int i = 0; i < 12; i++) begin
            rst_n = vt[i].rst_n; start = vt[i].start; s_valid = vt[i].valid;
            base_addr = vt[i].base; num_rows = vt[i].rows; s_data = vt[i].data;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_wea", i), wea, vt[i].wea);
            chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("v%0d_done", i), done, vt[i].done);
            chk($sformatf("v%0d_ready", i), s_ready, vt[i].ready);
            chk($sformatf("v%0d_addr", i), addra[AL-1:0], vt[i].addr);
        end
        start = 0; s_valid = 0;
        rst_n = 0; cycle(); rst_n = 1;
        start = 1; base_addr = 3; num_rows = 1; cycle(); start = 0;
        for (int k = 0; k < 16; k++) begin
            s_valid = 1;
            for (int j = 0; j < XM; j++) s_data[j*DL +: DL] = 16 * k + j;
            cycle();
        end
        s_valid = 0; cycle(); cycle();
        start = 1; base_addr = 511; num_rows = 2; cycle(); start = 0;
        for (int k = 0; k < 32; k++) begin
            s_valid = 1; s_data = {$urandom, $urandom, $urandom, $urandom}; cycle();
        end
        s_valid = 0; cycle(); cycle();
        start = 1; base_addr = 20; num_rows = 1; cycle(); start = 0;
        for (int p = 0; p < 200 && (m_act || m_done); p++) begin
            s_valid = (p % 4 == 0) || (p % 4 == 3);
            s_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        s_valid = 0;
        start = 1; base_addr = 40; num_rows = 3; cycle(); start = 0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1; s_data = {$urandom, $urandom, $urandom, $urandom}; cycle();
        end
        rst_n = 0; cycle(); rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1; s_data = {$urandom, $urandom, $urandom, $urandom}; cycle();
        end
        s_valid = 0;
`ifdef BUFWR_ZERO_FILL_EN
        start = 1; zero_fill = 1; base_addr = 10; num_rows = 4; cycle(); start = 0; zero_fill = 0;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1; s_data = {$urandom, $urandom, $urandom, $urandom}; cycle();
        end
        s_valid = 0;
`endif
        for (int n = 0; n < 30; n++) begin
            run_job($urandom % 512, $urandom % 4, 2 + n % 3);
            if ($urandom % 5 == 0) begin rst_n = 0; cycle(); rst_n = 1; end
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/buffer_write_ctrl.md
BUFFER_WRITE_CTRL -- requirements
Module: buffer_write_ctrl

Interface
REQ-001 SHALL have parameter X_MAC, default 4, MAC lanes per mesh group.
REQ-002 SHALL have parameter X_MESH, default 16, mesh groups.
REQ-003 SHALL have parameter ADDR_LEN, default 9, bank address width.
REQ-004 SHALL have parameter DATA_LEN, default 32, word width; BUFFER_NUM = X_MAC*X_MESH; DATAWIDTH = BUFFER_NUM*DATA_LEN; ADDRWIDTH = BUFFER_NUM*ADDR_LEN.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port start, input, 1, one-cycle job request; sampled only in IDLE.
REQ-008 SHALL have port base_addr, input, ADDR_LEN, first bank address of the job, sampled with start.
REQ-009 SHALL have port num_rows, input, ADDR_LEN, address rows to fill, sampled with start.
REQ-010 SHALL have port s_data, input, X_MAC*DATA_LEN, one mesh group's words, lane j at bits [j*DATA_LEN +: DATA_LEN].
REQ-011 SHALL have ports s_valid (input, 1) and s_ready (output, 1), stream handshake; a beat transfers when both are high at a rising edge.
REQ-012 SHALL have port dina, output, DATAWIDTH, BufferPool port-A data; bank (i,j) at bits [j*DATA_LEN+i*DATA_LEN*X_MAC +: DATA_LEN].
REQ-013 SHALL have port addra, output, ADDRWIDTH, port-A addresses; bank (i,j) at bits [j*ADDR_LEN+i*ADDR_LEN*X_MAC +: ADDR_LEN].
REQ-014 SHALL have port wea, output, BUFFER_NUM, write enables; bank (i,j) at bit j+i*X_MAC.
REQ-015 SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM IDLE -> WRITE -> DONE -> IDLE; start in IDLE with num_rows>0 -> WRITE; with num_rows==0 -> DONE directly.
REQ-017 SHALL hold s_ready high in WRITE only, low in IDLE and DONE.
REQ-018 SHALL keep counters mesh index m (0..X_MESH-1) and address a (initialised to base_addr) plus row count r (initialised to 0).
REQ-019 SHALL, per transferred beat, drive on the next cycle: dina group m = s_data (all other groups hold last value), all addra fields = a, wea group m = all ones, all other wea bits 0 (one-cycle latency, registered outputs).
REQ-020 SHALL drive wea all zero in every cycle following no transfer.
REQ-021 SHALL increment m per beat; on m==X_MESH-1 wrap m to 0, increment a modulo 2^ADDR_LEN, increment r.
REQ-022 SHALL, when the beat with m==X_MESH-1 makes r reach num_rows, move to DONE; done SHALL be high exactly the cycle in DONE, concurrent with the final wea write.
REQ-023 SHALL ignore start while busy; SHALL ignore s_valid outside WRITE.
REQ-024 SHALL tolerate s_valid gaps of any length with no state change and no writes.

Reset
REQ-025 SHALL, when rst_n is low at a rising edge, force IDLE, m=0, r=0, a=0, dina=0, addra=0, wea=0, s_ready=0, busy=0, done=0, including mid-job; the aborted job SHALL NOT resume.

Configuration
REQ-026 SHALL compile zero-fill support only when macro BUFWR_ZERO_FILL_EN is defined: adds input zero_fill (1), sampled with start; if high, WRITE ignores the stream (s_ready=0) and each cycle writes zero to all BUFFER_NUM banks at address a, a increments per cycle, done after num_rows cycles.
REQ-027 SHALL, without BUFWR_ZERO_FILL_EN, have no zero_fill port and no zero-fill logic.

Verification
REQ-028 Reset then start, base_addr=3, num_rows=1, 16 back-to-back beats lane j = 16*k+j -> beat k writes group k at addr 3 next cycle, wea = 0xF<<(4k); done with beat 15's write.
REQ-029 base_addr=511, num_rows=2, 32 beats -> rows at 511 then 0 (wrap); done after beat 31.
REQ-030 s_valid toggled 1,0,0,1 during WRITE -> wea zero in gap cycles; m advances only on transfers.
REQ-031 start with num_rows=0 -> DONE next cycle, done one pulse, no wea activity; second start while busy ignored.
REQ-032 rst_n low after 5 beats -> all outputs 0 next cycle, IDLE; later beats produce no writes until new start.
REQ-033 With BUFWR_ZERO_FILL_EN, zero_fill=1, base_addr=10, num_rows=4 -> wea all ones, dina 0, addra 10..13 on 4 consecutive cycles, s_ready stays 0, done on the 4th.
